// File: rtl/rob_pkg.sv
// ROB shared definitions: sizing constants and the ROB entry layout.
// Shared between the dispatch writer and the ROB bank FIFOs.
package rob_pkg;

    localparam int NUM_ROB_ENTS   = 32;
    localparam int NUM_ROB_BANKS  = 4;
    localparam int DISPATCH_WIDTH = 2;
    localparam int PC_W           = 32;
    localparam int AREG_W         = 5;
    localparam int PREG_W         = 6;

    localparam int ROB_TAG_W = $clog2(NUM_ROB_ENTS);
    localparam int CNT_W     = ROB_TAG_W + 1;
    localparam int BANK_W    = $clog2(NUM_ROB_BANKS);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              has_dest;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
    } rob_entry_t;

    localparam int ENT_W = $bits(rob_entry_t);

endpackage

// File: rtl/rob_bank_router.sv
// Combinational router from the two compacted dispatch slots to the four
// ROB bank write lanes.
// Ports:
//   valid_i  - per-slot valid of the compacted pair
//   bank_i   - per-slot bank index (low bits of the ROB tag)
//   ent_i    - per-slot rob_entry_t
//   w_en_o   - per-bank write enable
//   w_data_o - per-bank write data (zero when the bank is not written)
// Consecutive tags always land in different banks, so at most one slot
// hits any bank; slot 0 is still given precedence to keep the mux simple.
module rob_bank_router
    import rob_pkg::*;
(
    input  logic [DISPATCH_WIDTH-1:0]        valid_i,
    input  logic [DISPATCH_WIDTH*BANK_W-1:0] bank_i,
    input  logic [DISPATCH_WIDTH*ENT_W-1:0]  ent_i,
    output logic [NUM_ROB_BANKS-1:0]         w_en_o,
    output logic [NUM_ROB_BANKS*ENT_W-1:0]   w_data_o
);

    generate
        for (genvar gi = 0; gi < NUM_ROB_BANKS; gi++) begin : g_bank
            logic hit0;
            logic hit1;
            assign hit0 = valid_i[0] && (bank_i[0 +: BANK_W] == BANK_W'(gi));
            assign hit1 = valid_i[1] && (bank_i[BANK_W +: BANK_W] == BANK_W'(gi));
            assign w_en_o[gi] = hit0 | hit1;
            assign w_data_o[gi*ENT_W +: ENT_W] = hit0 ? ent_i[0 +: ENT_W] :
                                                 (hit1 ? ent_i[ENT_W +: ENT_W] : '0);
        end
    endgenerate

endmodule

// File: rtl/rob_dispatch.sv
// Dispatch-side writer for the banked ROB. Accepts up to two renamed
// instructions per cycle, compacts them, assigns sequential ROB tags, and
// one cycle later writes each entry into ROB bank (tag % 4) while handing
// the tagged instructions to issue. Owns the ROB tail and occupancy count.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush_i           - pipeline flush: clears tail, count and output stage
//   in_valid_i        - per-slot valid from rename
//   in_ready_o        - group ready (depends on registered count only)
//   in_pc_i .. in_old_preg_i - per-slot instruction fields
//   retire_cnt_i      - entries retired this cycle (0..2)
//   rob_w_en_o/rob_w_data_o  - per-bank ROB FIFO write lanes
//   disp_valid_o/disp_tag_o/disp_preg_o - compacted issue slots
//   rob_count_o       - current ROB occupancy
module rob_dispatch
    import rob_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [DISPATCH_WIDTH-1:0]          in_valid_i,
    output logic                               in_ready_o,
    input  logic [DISPATCH_WIDTH*PC_W-1:0]     in_pc_i,
    input  logic [DISPATCH_WIDTH-1:0]          in_has_dest_i,
    input  logic [DISPATCH_WIDTH*AREG_W-1:0]   in_areg_i,
    input  logic [DISPATCH_WIDTH*PREG_W-1:0]   in_preg_i,
    input  logic [DISPATCH_WIDTH*PREG_W-1:0]   in_old_preg_i,
    input  logic [1:0]                         retire_cnt_i,
    output logic [NUM_ROB_BANKS-1:0]           rob_w_en_o,
    output logic [NUM_ROB_BANKS*ENT_W-1:0]     rob_w_data_o,
    output logic [DISPATCH_WIDTH-1:0]          disp_valid_o,
    output logic [DISPATCH_WIDTH*ROB_TAG_W-1:0] disp_tag_o,
    output logic [DISPATCH_WIDTH*PREG_W-1:0]   disp_preg_o,
    output logic [CNT_W-1:0]                   rob_count_o
);

    logic [ROB_TAG_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic [DISPATCH_WIDTH-1:0]           out_valid_q, out_valid_d;
    logic [DISPATCH_WIDTH*ROB_TAG_W-1:0] out_tag_q, out_tag_d;
    logic [DISPATCH_WIDTH*ENT_W-1:0]     out_ent_q, out_ent_d;

    rob_entry_t                slot_ent [DISPATCH_WIDTH];
    logic                      in_ready;
    logic                      accept;
    logic [1:0]                n_acc;
    logic [CNT_W-1:0]          cnt_sum;

    generate
        for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_slot
            always_comb begin
                slot_ent[gi]          = '0;
                slot_ent[gi].pc       = in_pc_i[gi*PC_W +: PC_W];
                slot_ent[gi].has_dest = in_has_dest_i[gi];
                slot_ent[gi].areg     = in_areg_i[gi*AREG_W +: AREG_W];
                slot_ent[gi].preg     = in_preg_i[gi*PREG_W +: PREG_W];
                slot_ent[gi].old_preg = in_old_preg_i[gi*PREG_W +: PREG_W];
            end
        end
    endgenerate

    always_comb begin
        // Conservative: always leaves room for a full two-wide group, so
        // ready never looks at how many slots are actually valid.
        in_ready = !rst && !flush_i && (count_q <= CNT_W'(NUM_ROB_ENTS - 2));
        accept   = in_ready && (|in_valid_i);
        n_acc    = accept ? ({1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]}) : 2'd0;
        cnt_sum  = count_q + CNT_W'(n_acc);

        tail_d  = tail_q + ROB_TAG_W'(n_acc);
        // Over-retire is illegal; clamp at empty rather than wrapping.
        count_d = (CNT_W'(retire_cnt_i) > cnt_sum) ? '0 : cnt_sum - CNT_W'(retire_cnt_i);

        out_valid_d = '0;
        out_tag_d   = '0;
        out_ent_d   = '0;
        if (n_acc != 2'd0) begin
            // A lone slot-1 instruction is moved down to output slot 0.
            out_valid_d[0]               = 1'b1;
            out_tag_d[0 +: ROB_TAG_W]    = tail_q;
            out_ent_d[0 +: ENT_W]        = in_valid_i[0] ? slot_ent[0] : slot_ent[1];
        end
        if (n_acc == 2'd2) begin
            out_valid_d[1]               = 1'b1;
            out_tag_d[ROB_TAG_W +: ROB_TAG_W] = tail_q + ROB_TAG_W'(1);
            out_ent_d[ENT_W +: ENT_W]    = slot_ent[1];
        end

        if (flush_i) begin
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = '0;
            out_tag_d   = '0;
            out_ent_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= '0;
            out_tag_q   <= '0;
            out_ent_q   <= '0;
        end else begin
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_ent_q   <= out_ent_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (CNT_W'(retire_cnt_i) <= cnt_sum);
        end
    end

    // Outputs are forced quiet while reset is held, so an in-flight
    // output-stage group never reaches the ROB or issue.
    logic [DISPATCH_WIDTH-1:0]           vis_valid;
    logic [DISPATCH_WIDTH*ENT_W-1:0]     vis_ent;
    logic [DISPATCH_WIDTH*BANK_W-1:0]    vis_bank;

    assign vis_valid  = rst ? '0 : out_valid_q;
    assign vis_ent    = rst ? '0 : out_ent_q;
    assign in_ready_o = in_ready;
    assign disp_valid_o = vis_valid;
    assign disp_tag_o   = rst ? '0 : out_tag_q;
    assign rob_count_o  = rst ? '0 : count_q;

    generate
        for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_out
            rob_entry_t e;
            assign e = vis_ent[gi*ENT_W +: ENT_W];
            assign disp_preg_o[gi*PREG_W +: PREG_W] = e.preg;
            assign vis_bank[gi*BANK_W +: BANK_W] = out_tag_q[gi*ROB_TAG_W +: BANK_W];
        end
    endgenerate

    rob_bank_router u_router (
        .valid_i  (vis_valid),
        .bank_i   (vis_bank),
        .ent_i    (vis_ent),
        .w_en_o   (rob_w_en_o),
        .w_data_o (rob_w_data_o)
    );

endmodule

// File: tb/tb_rob_dispatch.sv
// Directed bench for rob_dispatch: reset, dual dispatch, fill/backpressure,
// accept-with-retire, flush, tag wrap, single slot-1 compaction, and reset
// discarding an in-flight group.
module tb_rob_dispatch;
    import rob_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  flush_i;
    logic [1:0]            in_valid_i;
    logic                  in_ready_o;
    logic [2*PC_W-1:0]     in_pc_i;
    logic [1:0]            in_has_dest_i;
    logic [2*AREG_W-1:0]   in_areg_i;
    logic [2*PREG_W-1:0]   in_preg_i;
    logic [2*PREG_W-1:0]   in_old_preg_i;
    logic [1:0]            retire_cnt_i;
    logic [3:0]            rob_w_en_o;
    logic [4*ENT_W-1:0]    rob_w_data_o;
    logic [1:0]            disp_valid_o;
    logic [2*ROB_TAG_W-1:0] disp_tag_o;
    logic [2*PREG_W-1:0]   disp_preg_o;
    logic [CNT_W-1:0]      rob_count_o;

    int checks = 0;
    int errors = 0;

    rob_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_pc_i       (in_pc_i),
        .in_has_dest_i (in_has_dest_i),
        .in_areg_i     (in_areg_i),
        .in_preg_i     (in_preg_i),
        .in_old_preg_i (in_old_preg_i),
        .retire_cnt_i  (retire_cnt_i),
        .rob_w_en_o    (rob_w_en_o),
        .rob_w_data_o  (rob_w_data_o),
        .disp_valid_o  (disp_valid_o),
        .disp_tag_o    (disp_tag_o),
        .disp_preg_o   (disp_preg_o),
        .rob_count_o   (rob_count_o)
    );

    // Instruction fields are derived from the PC so expected entries can be
    // rebuilt from the PC alone.
    function automatic logic [ENT_W-1:0] ent(input logic [31:0] pc);
        return {pc, pc[3], pc[6:2], pc[7:2], ~pc[7:2]};
    endfunction

    function automatic logic [5:0] preg(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    function automatic logic [4*ENT_W-1:0] wd(input logic [ENT_W-1:0] e3, e2, e1, e0);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [9:0] tags(input logic [4:0] t1, input logic [4:0] t0);
        return {t1, t0};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] ret, input logic fl);
        in_valid_i    = v;
        in_pc_i       = {p1, p0};
        in_has_dest_i = {p1[3], p0[3]};
        in_areg_i     = {p1[6:2], p0[6:2]};
        in_preg_i     = {p1[7:2], p0[7:2]};
        in_old_preg_i = {~p1[7:2], ~p0[7:2]};
        retire_cnt_i  = ret;
        flush_i       = fl;
    endtask

    task automatic cyc();
        $display("t=%0t rst=%b valid=%b retire=%0d flush=%b", $time, rst, in_valid_i, retire_cnt_i, flush_i);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("rst_w_en",   rob_w_en_o,   0);
        chk("rst_dvalid", disp_valid_o, 0);
        chk("rst_ready",  in_ready_o,   0);
        chk("rst_count",  rob_count_o,  0);
        chk("rst_wdata",  rob_w_data_o, 0);
        chk("rst_tag",    disp_tag_o,   0);
        chk("rst_preg",   disp_preg_o,  0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready_o, 1);

        // Dual dispatch from reset
        drive(2'b11, 32'h100, 32'h104, 0, 0);
        cyc();
        chk("t1_w_en",   rob_w_en_o,   4'b0011);
        chk("t1_dvalid", disp_valid_o, 2'b11);
        chk("t1_tag",    disp_tag_o,   tags(5'd1, 5'd0));
        chk("t1_count",  rob_count_o,  2);
        chk("t1_wdata",  rob_w_data_o, wd(0, 0, ent(32'h104), ent(32'h100)));
        chk("t1_preg",   disp_preg_o,  {preg(32'h104), preg(32'h100)});
        drive(2'b00, 0, 0, 0, 0);
        cyc();
        chk("t1_one_cycle_wen", rob_w_en_o,   0);
        chk("t1_one_cycle_dv",  disp_valid_o, 0);
        chk("t1_count_hold",    rob_count_o,  2);

        // Fill to 30, then a 16th group to 32
        for (int k = 0; k < 14; k++) begin
            drive(2'b11, 32'h1000 + 8 * k, 32'h1004 + 8 * k, 0, 0);
            cyc();
        end
        chk("t2_count30", rob_count_o, 30);
        chk("t2_ready30", in_ready_o,  1);
        chk("t2_tag_last", disp_tag_o, tags(5'd29, 5'd28));
        drive(2'b11, 32'h2000, 32'h2004, 0, 0);
        cyc();
        chk("t2_count32", rob_count_o, 32);
        chk("t2_ready32", in_ready_o,  0);
        chk("t2_w_en",    rob_w_en_o,  4'b1100);
        chk("t2_tag",     disp_tag_o,  tags(5'd31, 5'd30));
        drive(2'b11, 32'h2100, 32'h2104, 1, 0);
        cyc();
        chk("t2_count31", rob_count_o, 31);
        chk("t2_noacc_wen", rob_w_en_o, 0);
        chk("t2_ready31", in_ready_o,  0);
        cyc();
        chk("t2_count30b", rob_count_o, 30);
        chk("t2_noacc_wen2", rob_w_en_o, 0);
        chk("t2_ready30b", in_ready_o, 1);

        // Accept and retire 2 in the same cycle (tail wrapped to 0)
        drive(2'b11, 32'h200, 32'h204, 2, 0);
        cyc();
        chk("t5_count", rob_count_o, 30);
        chk("t5_ready", in_ready_o,  1);
        chk("t5_w_en",  rob_w_en_o,  4'b0011);
        chk("t5_tag",   disp_tag_o,  tags(5'd1, 5'd0));

        // Accept, then flush the next cycle
        drive(2'b11, 32'h300, 32'h304, 0, 0);
        cyc();
        chk("t6_w_en_acc", rob_w_en_o,  4'b1100);
        chk("t6_tag_acc",  disp_tag_o,  tags(5'd3, 5'd2));
        chk("t6_count32",  rob_count_o, 32);
        drive(2'b11, 32'h600, 32'h604, 1, 1);
        #1;
        chk("t6_ready_in_flush", in_ready_o, 0);
        chk("t6_write_in_flush", rob_w_en_o, 4'b1100);
        cyc();
        chk("t6_post_wen",   rob_w_en_o,   0);
        chk("t6_post_dv",    disp_valid_o, 0);
        chk("t6_post_count", rob_count_o,  0);
        drive(2'b00, 0, 0, 0, 0);
        #1;
        chk("t6_ready_after", in_ready_o, 1);
        drive(2'b01, 32'h400, 0, 0, 0);
        cyc();
        chk("t6_tag0",   disp_tag_o,   tags(5'd0, 5'd0));
        chk("t6_dv",     disp_valid_o, 2'b01);
        chk("t6_w_en",   rob_w_en_o,   4'b0001);
        chk("t6_wdata",  rob_w_data_o, wd(0, 0, 0, ent(32'h400)));
        chk("t6_count1", rob_count_o,  1);

        // Advance tail to 31 while retiring, then wrap
        for (int k = 0; k < 15; k++) begin
            drive(2'b11, 32'h3000 + 8 * k, 32'h3004 + 8 * k, 2, 0);
            cyc();
        end
        chk("t3_tag_pre",   disp_tag_o,  tags(5'd30, 5'd29));
        chk("t3_count_pre", rob_count_o, 1);
        drive(2'b11, 32'h700, 32'h704, 0, 0);
        cyc();
        chk("t3_tag_wrap", disp_tag_o,   tags(5'd0, 5'd31));
        chk("t3_w_en",     rob_w_en_o,   4'b1001);
        chk("t3_wdata",    rob_w_data_o, wd(ent(32'h700), 0, 0, ent(32'h704)));
        chk("t3_count",    rob_count_o,  3);

        // Tail to 5, then a lone slot-1 instruction
        drive(2'b11, 32'h800, 32'h804, 2, 0);
        cyc();
        drive(2'b11, 32'h808, 32'h80c, 2, 0);
        cyc();
        chk("t4_tag_pre",   disp_tag_o,  tags(5'd4, 5'd3));
        chk("t4_count_pre", rob_count_o, 3);
        drive(2'b10, 32'h0, 32'h900, 0, 0);
        cyc();
        chk("t4_dv",    disp_valid_o, 2'b01);
        chk("t4_tag",   disp_tag_o,   tags(5'd0, 5'd5));
        chk("t4_w_en",  rob_w_en_o,   4'b0010);
        chk("t4_wdata", rob_w_data_o, wd(0, 0, ent(32'h900), 0));
        chk("t4_preg",  disp_preg_o,  {6'd0, preg(32'h900)});
        chk("t4_count", rob_count_o,  4);
        drive(2'b01, 32'ha00, 0, 0, 0);
        cyc();
        chk("t4_tail6", disp_tag_o, tags(5'd0, 5'd6));
        chk("t4_w_en6", rob_w_en_o, 4'b0100);
        chk("t4_count5", rob_count_o, 5);

        // Reset while a group sits in the output stage
        drive(2'b11, 32'hb00, 32'hb04, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0);
        #1;
        chk("rstmid_w_en",  rob_w_en_o,   0);
        chk("rstmid_dv",    disp_valid_o, 0);
        chk("rstmid_ready", in_ready_o,   0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rstmid_after_wen",   rob_w_en_o,   0);
        chk("rstmid_after_dv",    disp_valid_o, 0);
        chk("rstmid_after_count", rob_count_o,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
